// File: rtl/egg_timer_pkg.sv
// ---------------------------------------------------------------------------
// egg_timer_pkg
// Shared definitions for the egg-timer time-entry controller.
//   state_t  : controller FSM encoding (SETUP, LOAD, RUN, DONE)
//   BCD_MAX  : largest legal BCD digit
//   TIME_W   : width of the two-digit BCD time value
//   bcd_inc  : single-digit BCD increment with 9 -> 0 wrap (no carry out)
// ---------------------------------------------------------------------------
package egg_timer_pkg;

    typedef enum logic [1:0] {
        SETUP = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam int         TIME_W  = 8;

    // Anything at or above 9 wraps to 0, so an entry digit can never leave 0..9.
    function automatic logic [3:0] bcd_inc(input logic [3:0] digit);
        return (digit >= BCD_MAX) ? 4'd0 : digit + 4'd1;
    endfunction

endpackage

// File: rtl/button_edge.sv
// ---------------------------------------------------------------------------
// button_edge
// Rising-edge detector for one debounced button level.
//   clk   : system clock
//   reset : synchronous, active-high reset
//   btn   : debounced button level
//   rise  : high for the cycle in which btn is 1 and was 0 on the previous edge
// The history register resets to 1 so that a button held through reset does
// not register as a press until it is released and pressed again.
// ---------------------------------------------------------------------------
module button_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic prev_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_reg <= 1'b1;
        end else begin
            prev_reg <= btn;
        end
    end

    assign rise = btn & ~prev_reg;

endmodule

// File: rtl/time_entry_ctrl.sv
// ---------------------------------------------------------------------------
// time_entry_ctrl
// Controller side of the egg-timer countdown: front-panel entry of a two-digit
// BCD time, a one-cycle load strobe into the countdown register, then paced
// decrement strobes until the register reports zero.
//   clk             : system clock
//   reset           : synchronous, active-high reset
//   btnUnits        : button level, rising edge = units digit +1
//   btnTens         : button level, rising edge = tens digit +1
//   btnStart        : button level, rising edge = start / acknowledge alarm
//   btnClear        : button level, rising edge = clear entry / abort run
//   countZero       : countdown register currently holds 8'h00
//   inputTime       : BCD entry {tens, units} presented to the countdown register
//   writeEnable     : one-cycle load strobe for inputTime (LOAD state)
//   decrementEnable : one-cycle decrement strobe (RUN state)
//   running         : high in LOAD and RUN
//   alarm           : high in DONE
// ---------------------------------------------------------------------------
module time_entry_ctrl
    import egg_timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btnUnits,
    input  logic              btnTens,
    input  logic              btnStart,
    input  logic              btnClear,
    input  logic              countZero,
    output logic [TIME_W-1:0] inputTime,
    output logic              writeEnable,
    output logic              decrementEnable,
    output logic              running,
    output logic              alarm
);

    localparam int            PS_W    = $clog2(TICK_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    // Button index map for the edge-detector bank.
    localparam int B_UNITS = 0;
    localparam int B_TENS  = 1;
    localparam int B_START = 2;
    localparam int B_CLEAR = 3;

    logic [3:0] btn_vec;
    logic [3:0] edge_vec;

    assign btn_vec = {btnClear, btnStart, btnTens, btnUnits};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn_edge
            button_edge u_edge (
                .clk   (clk),
                .reset (reset),
                .btn   (btn_vec[gi]),
                .rise  (edge_vec[gi])
            );
        end
    endgenerate

    state_t            state_reg,     state_next;
    logic [TIME_W-1:0] entry_reg,     entry_next;
    logic [PS_W-1:0]   prescaler_reg, prescaler_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= SETUP;
            entry_reg     <= '0;
            prescaler_reg <= '0;
        end else begin
            state_reg     <= state_next;
            entry_reg     <= entry_next;
            prescaler_reg <= prescaler_next;
        end
    end

    // Next-state logic. Per cycle, clear beats start, and start beats the
    // digit buttons; a lower-priority edge in the same cycle is dropped.
    always_comb begin
        state_next     = state_reg;
        entry_next     = entry_reg;
        prescaler_next = prescaler_reg;

        case (state_reg)
            SETUP: begin
                if (edge_vec[B_CLEAR]) begin
                    entry_next = '0;
                end else if (edge_vec[B_START]) begin
                    // Starting a zero-length countdown is meaningless; ignore it.
                    if (entry_reg != '0) begin
                        state_next = LOAD;
                    end
                end else begin
                    // Digits are independent: no carry from units into tens.
                    if (edge_vec[B_UNITS]) begin
                        entry_next[3:0] = bcd_inc(entry_reg[3:0]);
                    end
                    if (edge_vec[B_TENS]) begin
                        entry_next[7:4] = bcd_inc(entry_reg[7:4]);
                    end
                end
            end

            LOAD: begin
                prescaler_next = '0;
                state_next     = RUN;
            end

            RUN: begin
                if (edge_vec[B_CLEAR]) begin
                    // Abort keeps the entry so the user can restart quickly.
                    state_next     = SETUP;
                    prescaler_next = '0;
                end else if (countZero) begin
                    state_next     = DONE;
                    prescaler_next = '0;
                end else if (prescaler_reg == PS_LAST) begin
                    prescaler_next = '0;
                end else begin
                    prescaler_next = prescaler_reg + 1'b1;
                end
            end

            DONE: begin
                if (edge_vec[B_CLEAR]) begin
                    state_next = SETUP;
                    entry_next = '0;
                end else if (edge_vec[B_START]) begin
                    // Entry kept so the same time can be re-run immediately.
                    state_next = SETUP;
                end
            end

            default: begin
                state_next = SETUP;
            end
        endcase
    end

    // Strobes decode the registered state. Writes happen only in LOAD and
    // decrements only in RUN, so the two can never coincide; gating with
    // countZero keeps the countdown register from underflowing.
    assign inputTime       = entry_reg;
    assign writeEnable     = (state_reg == LOAD);
    assign decrementEnable = (state_reg == RUN) && (prescaler_reg == PS_LAST) && !countZero;
    assign running         = (state_reg == LOAD) || (state_reg == RUN);
    assign alarm           = (state_reg == DONE);

endmodule
